// File: rtl/input_conditioner.sv
// Purpose: synchronise and debounce two slide switches and an active-low push button.
// Latency: in/changed update DB_CYCLES+3 edges after a new switch level; step DB_CYCLES+3 edges after a press.
// Backpressure: none; outputs are registered pulses/levels that the consumer samples every cycle.
module input_conditioner #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sw_raw,
    input  logic       key_n_raw,
    output logic [1:0] in,
    output logic       changed,
    output logic       step,
    output logic [1:0] key_state
);

    // Both counters stop at this value, so they can never wrap.
    localparam logic [7:0] CNT_MAX = 8'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        K_UP      = 2'b00,
        K_DN_WAIT = 2'b01,
        K_DN      = 2'b10,
        K_UP_WAIT = 2'b11
    } key_state_t;

    logic [1:0] sw_s1;
    logic [1:0] sw_s2;
    logic       key_s1;
    logic       key_s2;

    logic [1:0] cand;
    logic [7:0] sw_cnt;

    key_state_t state_q;
    key_state_t state_nxt;
    logic [7:0] k_cnt;
    logic [7:0] k_cnt_nxt;
    logic       step_nxt;
    logic       pressed;

    // Two-flop synchronisers; key flops reset to released so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1  <= 2'b00;
            sw_s2  <= 2'b00;
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
        end else begin
            sw_s1  <= sw_raw;
            sw_s2  <= sw_s1;
            key_s1 <= key_n_raw;
            key_s2 <= key_s1;
        end
    end

    // Switch debounce: a candidate level must stay stable for DB_CYCLES cycles before it is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand    <= 2'b00;
            sw_cnt  <= 8'd0;
            in      <= 2'b00;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (sw_s2 != cand) begin
                cand   <= sw_s2;
                sw_cnt <= 8'd0;
            end else if (cand != in && sw_cnt == CNT_MAX) begin
                in      <= cand;
                changed <= 1'b1;
                sw_cnt  <= 8'd0;
            end else if (cand != in) begin
                sw_cnt <= sw_cnt + 8'd1;
            end else begin
                sw_cnt <= 8'd0;
            end
        end
    end

    assign pressed = ~key_s2;

    // Button FSM registers: state, stability counter and the one-shot step pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= K_UP;
            k_cnt   <= 8'd0;
            step    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            k_cnt   <= k_cnt_nxt;
            step    <= step_nxt;
        end
    end

    // Button FSM next state: step fires only on the confirmed press, never on release bounce.
    always_comb begin
        state_nxt = state_q;
        k_cnt_nxt = k_cnt;
        step_nxt  = 1'b0;
        unique case (state_q)
            K_UP: begin
                if (pressed) begin
                    state_nxt = K_DN_WAIT;
                    k_cnt_nxt = 8'd0;
                end
            end
            K_DN_WAIT: begin
                if (!pressed) begin
                    state_nxt = K_UP;
                end else if (k_cnt == CNT_MAX) begin
                    state_nxt = K_DN;
                    step_nxt  = 1'b1;
                end else begin
                    k_cnt_nxt = k_cnt + 8'd1;
                end
            end
            K_DN: begin
                if (!pressed) begin
                    state_nxt = K_UP_WAIT;
                    k_cnt_nxt = 8'd0;
                end
            end
            K_UP_WAIT: begin
                if (pressed) begin
                    state_nxt = K_DN;
                end else if (k_cnt == CNT_MAX) begin
                    state_nxt = K_UP;
                end else begin
                    k_cnt_nxt = k_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = K_UP;
                k_cnt_nxt = 8'd0;
            end
        endcase
    end

    assign key_state = state_q;

endmodule
